// File: rtl/mini_cpu_pkg.sv
// Shared definitions for the Mini-CPU front end.
//   WIDTH       : instruction word width
//   DEPTH / AW  : program ROM depth and address width
//   FETCH_CNT_W : width of the accepted-instruction counter
//   fetch_entry_t : one prefetch queue slot, {pc, instr}
package mini_cpu_pkg;

  localparam int WIDTH       = 16;
  localparam int DEPTH       = 256;
  localparam int AW          = $clog2(DEPTH);
  localparam int FETCH_CNT_W = 16;

  typedef struct packed {
    logic [AW-1:0]    pc;
    logic [WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO used as the instruction prefetch queue.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : drop every entry (takes priority over push/pop)
//   push       : write push_data at the tail; caller only pushes when a
//                slot is free or a pop happens in the same cycle
//   pop        : advance the head (ignored when empty)
//   head_data  : registered entry at the head (zero after reset)
//   count      : occupancy 0..2
//   full/empty : occupancy flags
module fetch_queue
  import mini_cpu_pkg::*;
#(
  parameter int EW = $bits(fetch_entry_t)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [EW-1:0] push_data,
  input  logic          pop,
  output logic [EW-1:0] head_data,
  output logic [1:0]    count,
  output logic          full,
  output logic          empty
);

  logic [EW-1:0] mem_reg [2];
  logic          head_reg, head_next;
  logic          tail_reg, tail_next;
  logic [1:0]    count_reg, count_next;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count_reg == 2'd0);
  assign full    = (count_reg == 2'd2);
  assign pop_ok  = pop && !empty && !flush;
  assign push_ok = push && !flush;

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (flush) begin
      head_next  = 1'b0;
      tail_next  = 1'b0;
      count_next = 2'd0;
    end else begin
      if (pop_ok)  head_next = ~head_reg;
      if (push_ok) tail_next = ~tail_reg;
      case ({push_ok, pop_ok})
        2'b10:   count_next = count_reg + 2'd1;
        2'b01:   count_next = count_reg - 2'd1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= 1'b0;
      tail_reg  <= 1'b0;
      count_reg <= 2'd0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // When full with a simultaneous pop, tail equals head, so the new word
  // lands in the slot being vacated while head moves to the older survivor.
  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (rst) begin
        mem_reg[gi] <= '0;
      end else if (push_ok && (tail_reg == 1'(gi))) begin
        mem_reg[gi] <= push_data;
      end
    end
  end

  assign head_data = mem_reg[head_reg];
  assign count     = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, ROM address drive, prefetch queue
// and a saturating count of instructions handed to decode.
//   clk, rst            : clock, synchronous active-high reset
//   rom_addr/rom_data   : combinational program ROM port (addr = pc)
//   out_valid/out_ready : decode handshake; out_instr/out_pc = queue head
//   redirect_valid/addr : load a new pc and flush the queue
//   halt                : suspend fetching (queue still drains)
//   fetch_count         : accepted instructions, saturating
module fetch_unit
  import mini_cpu_pkg::*;
#(
  parameter int WIDTH = mini_cpu_pkg::WIDTH,
  parameter int DEPTH = mini_cpu_pkg::DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [AW-1:0]          rom_addr,
  input  logic [WIDTH-1:0]       rom_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_instr,
  output logic [AW-1:0]          out_pc,
  input  logic                   redirect_valid,
  input  logic [AW-1:0]          redirect_addr,
  input  logic                   halt,
  output logic [FETCH_CNT_W-1:0] fetch_count
);

  localparam int EW = AW + WIDTH;

  logic [AW-1:0]          pc_reg, pc_next;
  logic [FETCH_CNT_W-1:0] fetch_count_reg, fetch_count_next;
  logic [EW-1:0]          head_data;
  logic [1:0]             q_count;
  logic                   q_full;
  logic                   q_empty;
  logic                   handshake;
  logic                   fetch_en;

  assign handshake = !q_empty && out_ready;
  // A full queue still accepts a word when the head leaves this cycle.
  assign fetch_en  = !halt && !redirect_valid && (!q_full || handshake);

  always_comb begin
    pc_next = pc_reg;
    if (redirect_valid) begin
      pc_next = redirect_addr;
    end else if (fetch_en) begin
      pc_next = (pc_reg == AW'(DEPTH - 1)) ? '0 : pc_reg + 1'b1;
    end
  end

  always_comb begin
    fetch_count_next = fetch_count_reg;
    if (handshake && (fetch_count_reg != '1)) begin
      fetch_count_next = fetch_count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg          <= '0;
      fetch_count_reg <= '0;
    end else begin
      pc_reg          <= pc_next;
      fetch_count_reg <= fetch_count_next;
    end
  end

  fetch_queue #(
    .EW (EW)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (fetch_en),
    .push_data ({pc_reg, rom_data}),
    .pop       (handshake),
    .head_data (head_data),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign rom_addr    = pc_reg;
  assign out_valid   = !q_empty;
  assign out_pc      = head_data[EW-1:WIDTH];
  assign out_instr   = head_data[WIDTH-1:0];
  assign fetch_count = fetch_count_reg;

  logic unused_ok;
  assign unused_ok = ^q_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model checked every cycle,
// plus directed literal expectations along the documented scenarios.
module tb_fetch_unit;
  import mini_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [7:0]  out_pc;
  logic        redirect_valid;
  logic [7:0]  redirect_addr;
  logic        halt;
  logic [15:0] fetch_count;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;
  bit verbose = 1'b1;

  always #5 clk = ~clk;

  // ROM contents: address 3 holds the all-zero default word.
  function automatic logic [15:0] rom_fn(input logic [7:0] a);
    if (a == 8'h03) return 16'h0000;
    return {a ^ 8'hA5, ~a};
  endfunction

  assign rom_data = rom_fn(rom_addr);

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .halt           (halt),
    .fetch_count    (fetch_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of {pc, instr} words.
  logic [23:0] mq[$];
  logic [7:0]  m_pc = 8'h00;
  int          m_fc = 0;
  bit          m_hs;

  always @(posedge clk) begin
    m_hs = (mq.size() > 0) && out_ready;
    if (rst) begin
      mq.delete();
      m_pc = 8'h00;
      m_fc = 0;
    end else begin
      if (m_hs && m_fc < 65535) m_fc++;
      if (redirect_valid) begin
        mq.delete();
        m_pc = redirect_addr;
      end else begin
        if (m_hs) void'(mq.pop_front());
        if (!halt && mq.size() < 2) begin
          mq.push_back({m_pc, rom_fn(m_pc)});
          m_pc = m_pc + 8'd1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_rom_addr", rom_addr, m_pc);
      check("m_out_valid", out_valid, mq.size() > 0);
      check("m_fetch_count", fetch_count, m_fc);
      if (mq.size() > 0) begin
        check("m_out_pc", out_pc, mq[0][23:16]);
        check("m_out_instr", out_instr, mq[0][15:0]);
        if (verbose && out_ready)
          $display("[TB] accept pc=%02h instr=%04h count=%0d", out_pc, out_instr, fetch_count);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit found;
    rst = 1'b1; out_ready = 1'b0; halt = 1'b0;
    redirect_valid = 1'b0; redirect_addr = 8'h00;
    tick(); tick();
    check("rst_valid", out_valid, 0);
    check("rst_pc", out_pc, 0);
    check("rst_instr", out_instr, 0);
    check("rst_count", fetch_count, 0);
    check("rst_rom_addr", rom_addr, 0);
    cmp_en = 1'b1;

    // Backpressure from reset release: cycles 0..4 with out_ready low.
    rst = 1'b0;
    check("c0_valid", out_valid, 0);
    tick();
    check("c1_valid", out_valid, 1);
    check("c1_pc", out_pc, 8'h00);
    check("c1_instr", out_instr, 16'hA5FF);
    tick(); tick(); tick();
    check("bp_rom_addr", rom_addr, 8'h02);
    check("bp_pc_hold", out_pc, 8'h00);
    out_ready = 1'b1;
    tick();
    check("bp_rel_pc1", out_pc, 8'h01);
    tick();
    check("bp_rel_pc2", out_pc, 8'h02);
    tick();
    check("bp_rel_pc3", out_pc, 8'h03);
    check("zero_word", out_instr, 16'h0000);
    check("bp_count", fetch_count, 3);

    // Redirect to 0C during the handshake of pc 5.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (out_valid && out_pc == 8'h05) found = 1'b1;
      else tick();
    end
    check("wait_pc5", found, 1);
    redirect_valid = 1'b1; redirect_addr = 8'h0C;
    tick();
    redirect_valid = 1'b0;
    check("rd_valid", out_valid, 0);
    check("rd_rom_addr", rom_addr, 8'h0C);
    check("rd_count", fetch_count, 6);
    tick();
    check("rd_pc0c", out_pc, 8'h0C);
    check("rd_valid2", out_valid, 1);
    tick();
    check("rd_pc0d", out_pc, 8'h0D);

    // Halt for 4 cycles: out_ready low twice, then high.
    out_ready = 1'b0;
    tick();
    halt = 1'b1;
    check("h0_rom_addr", rom_addr, 8'h0F);
    tick();
    check("h1_rom_addr", rom_addr, 8'h0F);
    check("h1_pc", out_pc, 8'h0D);
    tick();
    out_ready = 1'b1;
    check("h2_rom_addr", rom_addr, 8'h0F);
    check("h2_pc", out_pc, 8'h0D);
    tick();
    check("h3_rom_addr", rom_addr, 8'h0F);
    check("h3_pc", out_pc, 8'h0E);
    tick();
    halt = 1'b0;
    check("h4_valid", out_valid, 0);
    check("h4_rom_addr", rom_addr, 8'h0F);
    tick();
    check("h5_pc", out_pc, 8'h0F);

    // Wrap at the top of the address space.
    redirect_valid = 1'b1; redirect_addr = 8'hFF;
    tick();
    redirect_valid = 1'b0;
    check("w_valid", out_valid, 0);
    check("w_rom_addr", rom_addr, 8'hFF);
    tick();
    check("w_pcff", out_pc, 8'hFF);
    check("w_instr", out_instr, 16'h5A00);
    tick();
    check("w_pc00", out_pc, 8'h00);
    tick();
    check("w_pc01", out_pc, 8'h01);

    // Saturation of the accepted-instruction counter.
    verbose = 1'b0;
    repeat (65600) tick();
    verbose = 1'b1;
    check("sat_count", fetch_count, 16'hFFFF);
    tick();
    check("sat_hold", fetch_count, 16'hFFFF);

    // Reset while the queue is full and fetching is halted.
    out_ready = 1'b0;
    tick(); tick();
    halt = 1'b1;
    tick();
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    tick();
    check("rr_valid", out_valid, 0);
    check("rr_rom_addr", rom_addr, 0);
    check("rr_count", fetch_count, 0);
    rst = 1'b0; halt = 1'b0;
    check("rr_c0_valid", out_valid, 0);
    tick();
    check("rr_c1_valid", out_valid, 1);
    check("rr_c1_pc", out_pc, 8'h00);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
